gera_asteroides: RTL and testbench

Asteroid spawner, the writer side of the asteroid table. The collision comparator reads this table and clears entries by marking them destroyed. This block refills it. On each spawn request it scans the table for a free slot (not loaded, or loaded and destroyed), writes one new asteroid on a screen border with an inward heading, and reports done or table-full. It sits beside the comparator in the game datapath and shares the asteroid memory write port under control-unit arbitration.

---
 rtl/gera_asteroides_if.sv | 34 +++
 rtl/gera_asteroides.sv | 146 ++++++++++++++
 tb/tb_gera_asteroides.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gera_asteroides_if.sv
// Asteroid spawner bus: spawn request, asteroid table read/write port, status pulses.
interface gera_asteroides_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              gera_asteroide;
    logic              aste_loaded_in;
    logic              aste_destruido_in;
    logic [ADDR_W-1:0] aste_addr;
    logic              we_aste;
    logic              new_load_aste;
    logic              new_destruido_aste;
    logic [3:0]        new_coor_x;
    logic [3:0]        new_coor_y;
    logic [2:0]        new_opcode_aste;
    logic              sinal_fim_geracao;
    logic              sinal_tabela_cheia;
    logic [4:0]        db_estado_gera_asteroides;

    // Spawner side
    modport master (
        input  gera_asteroide, aste_loaded_in, aste_destruido_in,
        output aste_addr, we_aste, new_load_aste, new_destruido_aste,
               new_coor_x, new_coor_y, new_opcode_aste,
               sinal_fim_geracao, sinal_tabela_cheia, db_estado_gera_asteroides
    );

    // Control unit / memory side
    modport slave (
        output gera_asteroide, aste_loaded_in, aste_destruido_in,
        input  aste_addr, we_aste, new_load_aste, new_destruido_aste,
               new_coor_x, new_coor_y, new_opcode_aste,
               sinal_fim_geracao, sinal_tabela_cheia, db_estado_gera_asteroides
    );
endinterface

// File: rtl/gera_asteroides.sv
// Asteroid spawner: scans the asteroid table for a free slot and writes one border asteroid.
// Optional macro GERA_ASTEROIDES_ROUND_ROBIN_EN starts each scan after the last written slot.
module gera_asteroides #(
    parameter int unsigned N_ASTE = 16,
    parameter int unsigned ADDR_W = 4,
    parameter logic [7:0]  SEED   = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    gera_asteroides_if.master bus
);
    localparam logic [4:0] INICIAL        = 5'b00000;
    localparam logic [4:0] ZERA_CONTADOR  = 5'b00001;
    localparam logic [4:0] LE_SLOT        = 5'b00010;
    localparam logic [4:0] ESPERA_LEITURA = 5'b00011;
    localparam logic [4:0] VERIFICA       = 5'b00100;
    localparam logic [4:0] PROXIMO        = 5'b00101;
    localparam logic [4:0] ESCREVE        = 5'b00110;
    localparam logic [4:0] FIM            = 5'b00111;
    localparam logic [4:0] CHEIA          = 5'b01000;

    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(N_ASTE - 1);

    logic [4:0]        state;
    logic [4:0]        state_next;
    logic [7:0]        lfsr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] scan;
    logic [ADDR_W-1:0] start_addr;
    logic              writing;
    logic [3:0]        place_x;
    logic [3:0]        place_y;
    logic [2:0]        place_op;
    logic              we_q;
    logic              fim_q;
    logic              cheia_q;
    logic [3:0]        x_q;
    logic [3:0]        y_q;
    logic [2:0]        op_q;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= INICIAL;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            INICIAL:        if (bus.gera_asteroide) state_next = ZERA_CONTADOR;
            ZERA_CONTADOR:  state_next = LE_SLOT;
            LE_SLOT:        state_next = ESPERA_LEITURA;
            ESPERA_LEITURA: state_next = VERIFICA;
            VERIFICA: begin
                if (!bus.aste_loaded_in || bus.aste_destruido_in) state_next = ESCREVE;
                else if (scan == LAST_SLOT)                       state_next = CHEIA;
                else                                              state_next = PROXIMO;
            end
            PROXIMO:        state_next = LE_SLOT;
            ESCREVE:        state_next = FIM;
            FIM:            state_next = INICIAL;
            CHEIA:          state_next = INICIAL;
            default:        state_next = INICIAL;
        endcase
    end

    // Free-running LFSR, x^8 + x^6 + x^5 + x^4 + 1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= SEED;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

`ifdef GERA_ASTEROIDES_ROUND_ROBIN_EN
    logic [ADDR_W-1:0] last_written;

    // Resetting to the top slot makes the first scan start at 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 last_written <= LAST_SLOT;
        else if (state == ESCREVE) last_written <= addr;
    end

    assign start_addr = last_written + ADDR_W'(1);
`else
    assign start_addr = '0;
`endif

    // Slot address and scan-length counters; address wraps mod N_ASTE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr <= '0;
            scan <= '0;
        end else if (state == ZERA_CONTADOR) begin
            addr <= start_addr;
            scan <= '0;
        end else if (state == PROXIMO) begin
            addr <= addr + ADDR_W'(1);
            scan <= scan + ADDR_W'(1);
        end
    end

    // Border placement: side from L[1:0], position from L[7:4]
    always_comb begin
        place_x  = lfsr[7:4];
        place_y  = 4'h0;
        place_op = 3'b001;
        case (lfsr[1:0])
            2'b00: begin place_x = lfsr[7:4]; place_y = 4'h0;      place_op = 3'b001; end
            2'b01: begin place_x = lfsr[7:4]; place_y = 4'hF;      place_op = 3'b000; end
            2'b10: begin place_x = 4'h0;      place_y = lfsr[7:4]; place_op = 3'b011; end
            default: begin place_x = 4'hF;    place_y = lfsr[7:4]; place_op = 3'b010; end
        endcase
    end

    assign writing = (state_next == ESCREVE);

    // Moore outputs registered alongside the state; coordinates snapshot the LFSR on entry to escreve
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            fim_q   <= 1'b0;
            cheia_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
        end else begin
            we_q    <= writing;
            fim_q   <= (state_next == FIM);
            cheia_q <= (state_next == CHEIA);
            x_q     <= writing ? place_x  : 4'h0;
            y_q     <= writing ? place_y  : 4'h0;
            op_q    <= writing ? place_op : 3'b000;
        end
    end

    assign bus.aste_addr                 = addr;
    assign bus.we_aste                   = we_q;
    assign bus.new_load_aste             = we_q;
    assign bus.new_destruido_aste        = 1'b0;
    assign bus.new_coor_x                = x_q;
    assign bus.new_coor_y                = y_q;
    assign bus.new_opcode_aste           = op_q;
    assign bus.sinal_fim_geracao         = fim_q;
    assign bus.sinal_tabela_cheia        = cheia_q;
    assign bus.db_estado_gera_asteroides = state;
endmodule

// File: tb/tb_gera_asteroides.sv
// Self-checking bench for gera_asteroides: behavioural table/LFSR model, randomized occupancy.
module tb_gera_asteroides;
    localparam int N = 16;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    gera_asteroides_if #(.ADDR_W(4)) bus ();

    gera_asteroides #(.N_ASTE(16), .ADDR_W(4), .SEED(8'hA5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Asteroid table as seen by the spawner, one-cycle synchronous read
    bit mem_ld [N];
    bit mem_ds [N];
    always @(posedge clock) begin
        bus.aste_loaded_in    <= mem_ld[bus.aste_addr];
        bus.aste_destruido_in <= mem_ds[bus.aste_addr];
    end

    // Reference LFSR; m_prev is the value held just before the most recent edge
    logic [7:0] m_lfsr;
    logic [7:0] m_prev;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

`ifdef GERA_ASTEROIDES_ROUND_ROBIN_EN
    int m_last = N - 1;
    function automatic int start_slot();
        return (m_last + 1) % N;
    endfunction
`else
    function automatic int start_slot();
        return 0;
    endfunction
`endif

    // Results of the latest request
    int         r_fim, r_cheia, r_writes;
    logic [3:0] r_addr, r_x, r_y;
    logic [2:0] r_op;
    logic       r_ld, r_ds;
    logic [7:0] r_L;
    logic [4:0] r_end_state;

    // Raise a request at the current negedge and observe until a done/full pulse
    task automatic do_request(input int budget, input bit hold_req);
        r_fim = -1; r_cheia = -1; r_writes = 0;
        r_addr = '0; r_x = '0; r_y = '0; r_op = '0; r_ld = 1'b0; r_ds = 1'b0; r_L = '0;
        bus.gera_asteroide = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clock);
            if (!hold_req) bus.gera_asteroide = 1'b0;
            if (bus.we_aste === 1'b1) begin
                r_writes++;
                r_addr = bus.aste_addr;  r_x  = bus.new_coor_x;    r_y  = bus.new_coor_y;
                r_op   = bus.new_opcode_aste;
                r_ld   = bus.new_load_aste; r_ds = bus.new_destruido_aste;
                r_L    = m_prev;
            end
            if (bus.sinal_fim_geracao === 1'b1)  r_fim   = c;
            if (bus.sinal_tabela_cheia === 1'b1) r_cheia = c;
            if (r_fim >= 0 || r_cheia >= 0) break;
        end
        bus.gera_asteroide = 1'b0;
        @(negedge clock);
        if (bus.we_aste === 1'b1) r_writes++;
        r_end_state = bus.db_estado_gera_asteroides;
    endtask

    // One request against the current table contents, checked against the model
    task automatic test_spawn_case(input string name);
        int exp_k, exp_slot, ex, ey, eo, side, pos;
        exp_k = -1; exp_slot = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start_slot() + k) % N;
            if (!mem_ld[idx] || mem_ds[idx]) begin exp_k = k; exp_slot = idx; break; end
        end
        @(negedge clock);
        do_request(4 * N + 10, 1'b0);
        total++;
        if (r_end_state !== 5'b00000) begin
            bad++; $display("FAIL %s end_state got=%b exp=00000", name, r_end_state);
        end
        if (exp_k < 0) begin
            total++;
            if (r_writes !== 0) begin bad++; $display("FAIL %s full_writes got=%0d exp=0", name, r_writes); end
            total++;
            if (r_cheia !== 4 * N + 1 || r_fim !== -1) begin
                bad++; $display("FAIL %s full_latency cheia=%0d fim=%0d exp cheia=%0d", name, r_cheia, r_fim, 4 * N + 1);
            end
            return;
        end
        side = int'(r_L) % 4;
        pos  = int'(r_L) / 16;
        case (side)
            0: begin ex = pos; ey = 0;   eo = 1; end
            1: begin ex = pos; ey = 15;  eo = 0; end
            2: begin ex = 0;   ey = pos; eo = 3; end
            default: begin ex = 15; ey = pos; eo = 2; end
        endcase
        total++;
        if (r_writes !== 1) begin bad++; $display("FAIL %s writes got=%0d exp=1", name, r_writes); end
        total++;
        if (int'(r_addr) !== exp_slot) begin bad++; $display("FAIL %s addr got=%0d exp=%0d", name, r_addr, exp_slot); end
        total++;
        if (r_ld !== 1'b1 || r_ds !== 1'b0) begin
            bad++; $display("FAIL %s load/destr got=%b/%b exp=1/0", name, r_ld, r_ds);
        end
        total++;
        if (int'(r_x) !== ex || int'(r_y) !== ey || int'(r_op) !== eo) begin
            bad++; $display("FAIL %s placement L=%h got x=%0d y=%0d op=%0d exp x=%0d y=%0d op=%0d",
                            name, r_L, r_x, r_y, r_op, ex, ey, eo);
        end
        total++;
        if (r_fim !== 4 * exp_k + 6 || r_cheia !== -1) begin
            bad++; $display("FAIL %s latency fim=%0d cheia=%0d exp fim=%0d", name, r_fim, r_cheia, 4 * exp_k + 6);
        end
`ifdef GERA_ASTEROIDES_ROUND_ROBIN_EN
        m_last = exp_slot;
`endif
    endtask

    task automatic clear_table();
        for (int i = 0; i < N; i++) begin mem_ld[i] = 1'b0; mem_ds[i] = 1'b0; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.gera_asteroide = 1'b0;
        #1;
        total++;
        if (bus.db_estado_gera_asteroides !== 5'b00000 || bus.aste_addr !== 4'd0) begin
            bad++; $display("FAIL reset_state got st=%b addr=%0d exp 0/0", bus.db_estado_gera_asteroides, bus.aste_addr);
        end
        total++;
        if (bus.we_aste !== 1'b0 || bus.new_load_aste !== 1'b0 || bus.new_destruido_aste !== 1'b0) begin
            bad++; $display("FAIL reset_write got we=%b ld=%b ds=%b exp 0", bus.we_aste, bus.new_load_aste, bus.new_destruido_aste);
        end
        total++;
        if ({bus.new_coor_x, bus.new_coor_y, bus.new_opcode_aste} !== 11'd0) begin
            bad++; $display("FAIL reset_coords got x=%0d y=%0d op=%0d exp 0", bus.new_coor_x, bus.new_coor_y, bus.new_opcode_aste);
        end
        total++;
        if (bus.sinal_fim_geracao !== 1'b0 || bus.sinal_tabela_cheia !== 1'b0) begin
            bad++; $display("FAIL reset_pulses got fim=%b cheia=%b exp 0", bus.sinal_fim_geracao, bus.sinal_tabela_cheia);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (bus.db_estado_gera_asteroides !== 5'b00000 || bus.we_aste !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset got st=%b we=%b exp 00000/0", bus.db_estado_gera_asteroides, bus.we_aste);
        end
    endtask

    task automatic test_directed();
        clear_table();
        test_spawn_case("all_free");
        clear_table();
        for (int i = 0; i < 3; i++) mem_ld[i] = 1'b1;
        mem_ld[3] = 1'b1; mem_ds[3] = 1'b1;
        test_spawn_case("slot3_destroyed");
    endtask

    task automatic test_full();
        for (int i = 0; i < N; i++) begin mem_ld[i] = 1'b1; mem_ds[i] = 1'b0; end
        test_spawn_case("table_full");
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int dens;
            dens = 50 + 5 * it;
            for (int i = 0; i < N; i++) begin
                mem_ld[i] = ($urandom_range(0, 99) < dens);
                mem_ds[i] = ($urandom_range(0, 99) < 10);
            end
            repeat ($urandom_range(0, 7)) @(negedge clock);
            test_spawn_case($sformatf("random_%0d", it));
        end
    endtask

    // Time the request so the LFSR holds 8'h72 when escreve is entered (all slots free)
    task automatic test_placement_72();
        logic [7:0] v;
        bit         hit;
        clear_table();
        hit = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            v = lfsr_step(lfsr_step(lfsr_step(lfsr_step(m_lfsr))));
            if (v == 8'h72) begin hit = 1'b1; break; end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL placement72_timing got=no_match exp=72"); return; end
        do_request(20, 1'b0);
        total++;
        if (r_writes !== 1 || r_L !== 8'h72) begin
            bad++; $display("FAIL placement72_capture got writes=%0d L=%h exp 1/72", r_writes, r_L);
        end
        total++;
        if (r_x !== 4'd0 || r_y !== 4'd7 || r_op !== 3'b011) begin
            bad++; $display("FAIL placement72 got x=%0d y=%0d op=%b exp x=0 y=7 op=011", r_x, r_y, r_op);
        end
`ifdef GERA_ASTEROIDES_ROUND_ROBIN_EN
        m_last = int'(r_addr);
`endif
    endtask

    task automatic test_reset_mid_scan();
        bit hit;
        int stray;
        for (int i = 0; i < N; i++) begin mem_ld[i] = 1'b1; mem_ds[i] = 1'b0; end
        @(negedge clock);
        bus.gera_asteroide = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 4 * N + 8; c++) begin
            @(negedge clock);
            bus.gera_asteroide = 1'b0;
            if (bus.db_estado_gera_asteroides === 5'b00101 && bus.aste_addr === 4'd5) begin hit = 1'b1; break; end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL midscan_reach got=not_reached exp=proximo@5"); end
        reset = 1'b1;
        #1;
        total++;
        if (bus.db_estado_gera_asteroides !== 5'b00000 || bus.aste_addr !== 4'd0 || bus.we_aste !== 1'b0 ||
            bus.sinal_fim_geracao !== 1'b0 || bus.sinal_tabela_cheia !== 1'b0) begin
            bad++; $display("FAIL midscan_reset got st=%b addr=%0d we=%b fim=%b cheia=%b exp all 0",
                            bus.db_estado_gera_asteroides, bus.aste_addr, bus.we_aste,
                            bus.sinal_fim_geracao, bus.sinal_tabela_cheia);
        end
        @(negedge clock);
        reset = 1'b0;
`ifdef GERA_ASTEROIDES_ROUND_ROBIN_EN
        m_last = N - 1;
`endif
        clear_table();
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (bus.we_aste !== 1'b0) stray++;
        end
        total++;
        if (stray !== 0) begin bad++; $display("FAIL midscan_no_write got=%0d exp=0", stray); end
        mem_ld[0] = 1'b1; mem_ld[1] = 1'b1;
        test_spawn_case("after_reset_scan_from_0");
    endtask

    // Request held high re-triggers once back in inicial
    task automatic test_back_to_back();
        int addrs[2];
        int nw, exp1, exp2;
        clear_table();
        exp1 = start_slot();
`ifdef GERA_ASTEROIDES_ROUND_ROBIN_EN
        exp2 = (exp1 + 1) % N;
`else
        exp2 = 0;
`endif
        nw = 0;
        @(negedge clock);
        bus.gera_asteroide = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (bus.we_aste === 1'b1) begin
                if (nw < 2) addrs[nw] = int'(bus.aste_addr);
                nw++;
                if (nw == 2) bus.gera_asteroide = 1'b0;
            end
        end
        bus.gera_asteroide = 1'b0;
        total++;
        if (nw !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", nw); end
        else begin
            total++;
            if (addrs[0] !== exp1 || addrs[1] !== exp2) begin
                bad++; $display("FAIL b2b_addrs got=%0d,%0d exp=%0d,%0d", addrs[0], addrs[1], exp1, exp2);
            end
        end
`ifdef GERA_ASTEROIDES_ROUND_ROBIN_EN
        m_last = exp2;
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_full();
        test_random();
        test_placement_72();
        test_reset_mid_scan();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
